// File: rtl/div_unit.sv
// Multicycle signed divider: restoring shift-subtract on operand magnitudes,
// one quotient bit per cycle, then sign correction into the held hi/lo results.
module div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int RW = WIDTH + 1;
  localparam int SW = WIDTH + 2;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [RW-1:0]    r_q, r_d;
  logic             neg_q_q, neg_q_d;
  logic             neg_r_q, neg_r_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             div_zero_q, div_zero_d;

  logic [SW-1:0]    r_sh;
  logic             ge;

  // The magnitude of the most negative value is 2^(WIDTH-1), which still fits unsigned.
  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v);
    mag = v[WIDTH-1] ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v, input logic neg);
    apply_sign = neg ? -v : v;
  endfunction

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    q_d        = q_q;
    d_d        = d_q;
    r_d        = r_q;
    neg_q_d    = neg_q_q;
    neg_r_d    = neg_r_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    div_zero_d = 1'b0;
    r_sh       = {r_q, q_q[WIDTH-1]};
    ge         = (r_sh >= {2'b00, d_q});

    case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            state_d    = DONE;
            done_d     = 1'b1;
            div_zero_d = 1'b1;
          end else begin
            q_d     = mag(dividend);
            d_d     = mag(divisor);
            neg_q_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_r_d = dividend[WIDTH-1];
            r_d     = '0;
            cnt_d   = '0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        r_d   = ge ? RW'(r_sh - {2'b00, d_q}) : RW'(r_sh);
        q_d   = {q_q[WIDTH-2:0], ge};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        lo_d    = apply_sign(q_q, neg_q_q);
        hi_d    = apply_sign(r_q[WIDTH-1:0], neg_r_q);
        done_d  = 1'b1;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN) || (state_d == FIX);
  end

  // Registered state, datapath and outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      q_q        <= '0;
      d_q        <= '0;
      r_q        <= '0;
      neg_q_q    <= 1'b0;
      neg_r_q    <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      q_q        <= q_d;
      d_q        <= d_d;
      r_q        <= r_d;
      neg_q_q    <= neg_q_d;
      neg_r_q    <= neg_r_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed testbench for div_unit: latency, signed results, div-by-zero,
// overflow, ignored start while busy and asynchronous abort.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_fail   = 0;

  div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  // Pulses start for one edge, then observes 40 cycles (k = cycles after the accepting edge).
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input int repulse_at,
                        input logic [31:0] a2, input logic [31:0] b2,
                        output int first_done, output int n_done, output logic dz,
                        output logic busy1, output logic busy_any);
    @(negedge clk);
    dividend = a; divisor = b; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; dividend = 32'h0; divisor = 32'h0;
    first_done = -1; n_done = 0; dz = 1'b0; busy1 = 1'b0; busy_any = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) busy1 = busy;
      if (busy) busy_any = 1'b1;
      if (done) begin
        n_done++;
        if (first_done < 0) begin first_done = k; dz = div_zero; end
      end
      if (repulse_at != 0 && k == repulse_at) begin
        dividend = a2; divisor = b2; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; dividend = 32'h0; divisor = 32'h0;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; dividend = 32'h0; divisor = 32'h0;
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (div_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dz: got %b want 0", div_zero); end
    n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi: got %h want 0", hi); end
    n_checks++; if (lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo: got %h want 0", lo); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int fd, nd; logic dz, b1, ba;
    do_div(32'd100, 32'd7, 0, 32'h0, 32'h0, fd, nd, dz, b1, ba);
    n_checks++; if (b1 !== 1'b1) begin n_fail++; $display("FAIL basic_busy1: got %b want 1", b1); end
    n_checks++; if (fd != 34) begin n_fail++; $display("FAIL basic_latency: got %0d want 34", fd); end
    n_checks++; if (nd != 1) begin n_fail++; $display("FAIL basic_done_count: got %0d want 1", nd); end
    n_checks++; if (dz !== 1'b0) begin n_fail++; $display("FAIL basic_dz: got %b want 0", dz); end
    n_checks++; if (lo !== 32'd14) begin n_fail++; $display("FAIL basic_lo: got %h want %h", lo, 32'd14); end
    n_checks++; if (hi !== 32'd2) begin n_fail++; $display("FAIL basic_hi: got %h want %h", hi, 32'd2); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_signs();
    int fd, nd; logic dz, b1, ba;
    do_div(32'hFFFF_FFF9, 32'h2, 0, 32'h0, 32'h0, fd, nd, dz, b1, ba);
    n_checks++; if (lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL negdvd_lo: got %h want %h", lo, 32'hFFFF_FFFD); end
    n_checks++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL negdvd_hi: got %h want %h", hi, 32'hFFFF_FFFF); end
    do_div(32'd7, 32'hFFFF_FFFE, 0, 32'h0, 32'h0, fd, nd, dz, b1, ba);
    n_checks++; if (lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL negdvs_lo: got %h want %h", lo, 32'hFFFF_FFFD); end
    n_checks++; if (hi !== 32'h1) begin n_fail++; $display("FAIL negdvs_hi: got %h want %h", hi, 32'h1); end
    do_div(32'hFFFF_FF9C, 32'hFFFF_FFF9, 0, 32'h0, 32'h0, fd, nd, dz, b1, ba);
    n_checks++; if (lo !== 32'd14) begin n_fail++; $display("FAIL negboth_lo: got %h want %h", lo, 32'd14); end
    n_checks++; if (hi !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL negboth_hi: got %h want %h", hi, 32'hFFFF_FFFE); end
  endtask

  task automatic test_div_zero();
    int fd, nd; logic dz, b1, ba;
    do_div(32'd100, 32'd7, 0, 32'h0, 32'h0, fd, nd, dz, b1, ba);
    do_div(32'd5, 32'd0, 0, 32'h0, 32'h0, fd, nd, dz, b1, ba);
    n_checks++; if (fd != 1) begin n_fail++; $display("FAIL dz_latency: got %0d want 1", fd); end
    n_checks++; if (nd != 1) begin n_fail++; $display("FAIL dz_done_count: got %0d want 1", nd); end
    n_checks++; if (dz !== 1'b1) begin n_fail++; $display("FAIL dz_flag: got %b want 1", dz); end
    n_checks++; if (ba !== 1'b0) begin n_fail++; $display("FAIL dz_busy: got %b want 0", ba); end
    n_checks++; if (lo !== 32'd14) begin n_fail++; $display("FAIL dz_lo_kept: got %h want %h", lo, 32'd14); end
    n_checks++; if (hi !== 32'd2) begin n_fail++; $display("FAIL dz_hi_kept: got %h want %h", hi, 32'd2); end
  endtask

  task automatic test_overflow();
    int fd, nd; logic dz, b1, ba;
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h0, 32'h0, fd, nd, dz, b1, ba);
    n_checks++; if (lo !== 32'h8000_0000) begin n_fail++; $display("FAIL ovf_lo: got %h want %h", lo, 32'h8000_0000); end
    n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL ovf_hi: got %h want 0", hi); end
    n_checks++; if (dz !== 1'b0) begin n_fail++; $display("FAIL ovf_dz: got %b want 0", dz); end
    do_div(32'h8000_0000, 32'h1, 0, 32'h0, 32'h0, fd, nd, dz, b1, ba);
    n_checks++; if (lo !== 32'h8000_0000) begin n_fail++; $display("FAIL min_by_one_lo: got %h want %h", lo, 32'h8000_0000); end
    n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL min_by_one_hi: got %h want 0", hi); end
    do_div(32'h8000_0000, 32'd3, 0, 32'h0, 32'h0, fd, nd, dz, b1, ba);
    n_checks++; if (lo !== 32'hD555_5556) begin n_fail++; $display("FAIL min_by_three_lo: got %h want %h", lo, 32'hD555_5556); end
    n_checks++; if (hi !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL min_by_three_hi: got %h want %h", hi, 32'hFFFF_FFFE); end
  endtask

  task automatic test_back_to_back();
    int fd, nd; logic dz, b1, ba;
    do_div(32'd7, 32'hFFFF_FFFE, 0, 32'h0, 32'h0, fd, nd, dz, b1, ba);
    do_div(32'd100, 32'd7, 10, 32'd9, 32'd3, fd, nd, dz, b1, ba);
    n_checks++; if (fd != 34) begin n_fail++; $display("FAIL b2b_latency: got %0d want 34", fd); end
    n_checks++; if (nd != 1) begin n_fail++; $display("FAIL b2b_done_count: got %0d want 1", nd); end
    n_checks++; if (lo !== 32'd14) begin n_fail++; $display("FAIL b2b_lo: got %h want %h", lo, 32'd14); end
    n_checks++; if (hi !== 32'd2) begin n_fail++; $display("FAIL b2b_hi: got %h want %h", hi, 32'd2); end
  endtask

  task automatic test_reset_abort();
    int fd, nd; logic dz, b1, ba;
    int late_done;
    @(negedge clk);
    dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; dividend = 32'h0; divisor = 32'h0;
    for (int k = 1; k <= 15; k++) @(negedge clk);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy_before: got %b want 1", busy); end
    #2 reset = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done: got %b want 0", done); end
    n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL abort_hi: got %h want 0", hi); end
    n_checks++; if (lo !== 32'h0) begin n_fail++; $display("FAIL abort_lo: got %h want 0", lo); end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    late_done = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done || busy) late_done++;
    end
    n_checks++; if (late_done != 0) begin n_fail++; $display("FAIL abort_no_done: got %0d active cycles want 0", late_done); end
    do_div(32'd9, 32'd3, 0, 32'h0, 32'h0, fd, nd, dz, b1, ba);
    n_checks++; if (fd != 34) begin n_fail++; $display("FAIL post_abort_latency: got %0d want 34", fd); end
    n_checks++; if (lo !== 32'd3) begin n_fail++; $display("FAIL post_abort_lo: got %h want %h", lo, 32'd3); end
    n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL post_abort_hi: got %h want 0", hi); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signs();
    test_div_zero();
    test_overflow();
    test_back_to_back();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multicycle signed 32-bit divider for the DIV instruction.
- Restoring shift-subtract algorithm on operand magnitudes, one quotient bit per cycle, followed by sign correction.
- hi (remainder) and lo (quotient) are held and feed the downstream 32-bit 3-input write-back selector mux.
- Driven by the control unit via a start/done handshake; div_zero feeds the exception logic.

Parameters:
- WIDTH, 32, operand/result width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- start  input  1  request a division; sampled only in IDLE.
- dividend  input  WIDTH  signed dividend (rs), sampled on the accepting edge.
- divisor  input  WIDTH  signed divisor (rt), sampled on the accepting edge.
- busy  output  1  1 while in RUN or FIX.
- done  output  1  one-cycle pulse when hi/lo are updated, or when a div-by-zero is flagged.
- div_zero  output  1  one-cycle pulse, coincident with done, when divisor was 0.
- hi  output  WIDTH  remainder; holds its value until the next successful division.
- lo  output  WIDTH  quotient; holds its value until the next successful division.

Behaviour:
- Reset (reset=0, async):
  - Outputs: busy=0, done=0, div_zero=0, hi=0, lo=0.
  - State: state=IDLE, counter=0, internal registers=0.
  - Reset mid-division aborts it. Nothing partial ever reaches hi/lo.
- States: IDLE, RUN, FIX, DONE.
- IDLE:
  - start=1 with divisor!=0 at edge E:
    - latch |dividend| into Q, |divisor| into D.
    - latch neg_q = sign(dividend) XOR sign(divisor), neg_r = sign(dividend).
    - clear R (WIDTH+1 bits) and counter; go to RUN.
  - start=1 with divisor==0: go to DONE with div_zero=1.
  - start=0: remain in IDLE.
- RUN, one iteration per edge, WIDTH edges (E+1..E+WIDTH):
  - shift {R,Q} left by 1; trial = R - D.
  - trial non-negative: R = trial, Q[0] = 1; otherwise Q[0] = 0.
  - counter increments; after iteration WIDTH-1 go to FIX.
- FIX, edge E+WIDTH+1:
  - lo = neg_q ? -Q : Q.
  - hi = neg_r ? -R[WIDTH-1:0] : R[WIDTH-1:0].
  - done=1 for the following cycle; go to DONE.
- DONE: lasts one cycle, then IDLE. done (and div_zero, if set) is high during this cycle only.
- Latency:
  - normal: done visible WIDTH+2 cycles after the accepting edge (34 for WIDTH=32).
  - div-by-zero: done visible 1 cycle after the accepting edge.
- start while busy or in DONE: ignored and not queued. Operand changes during RUN have no effect.
- Division by zero: hi/lo keep their previous values; div_zero=1 and done=1 together for one cycle.
- Rounding: truncation toward zero. Remainder takes the dividend's sign; |hi| < |divisor|.
- Overflow: 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0. No flag raised.
- Magnitude of 0x80000000 is 2^31. The unsigned datapath must represent it without overflow, hence R of WIDTH+1 bits.
- busy is a registered output: 1 during RUN and FIX, 0 otherwise.
- hi/lo are only written in FIX.

Test Plan:
- Reset, then 100 / 7 with start pulsed at edge 0 -> busy=1 from cycle 1; done=1 at cycle 34 only; lo=14, hi=2; div_zero=0.
- -7 / 2 (0xFFFFFFF9 / 0x2) -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Also 7 / -2 -> lo=-3, hi=1.
- Load hi=2, lo=14 via the first test, then 5 / 0 -> div_zero=1 and done=1 exactly one cycle after start; busy never set; hi=2, lo=14 unchanged.
- 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. Also 0x80000000 / 1 -> lo=0x80000000, hi=0.
- Start 100/7, re-pulse start with 9/3 at cycle 10 -> second request ignored; result lo=14, hi=2 at cycle 34; exactly one done pulse.
- Start 100/7, assert reset=0 asynchronously at cycle 15 (between edges), release at cycle 17 -> busy/hi/lo/done go to 0 immediately; no done pulse follows. A new 9/3 then yields lo=3, hi=0 at 34 cycles after its start.
